// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the round-robin arbiter.
//   arb_state_e    - FSM state encoding (IDLE / GRANT / TURN)
//   HOLD_CNT_W     - width of the optional grant-length counter
//   onehot_to_bin  - converts a one-hot vector (up to 16 bits) to its index
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TURN  = 2'b10
    } arb_state_e;

    localparam int HOLD_CNT_W = 16;

    // An all-zero input returns 0, which matches gnt_id when nobody owns the bus.
    function automatic logic [3:0] onehot_to_bin(input logic [15:0] oh);
        logic [3:0] bin;
        bin = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                bin = bin | 4'(i);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req     [N-1:0]     request vector
//   rr_ptr  [ID_W-1:0]  index that currently has the highest priority
//   any                 at least one request is present
//   pick_id [ID_W-1:0]  first requester found searching rr_ptr, rr_ptr+1, ... (mod N)
module rr_pick #(
    parameter int N = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic            any,
    output logic [ID_W-1:0] pick_id
);

    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] prio_mask;
    logic [2*N-1:0] masked;
    int             first_idx;

    // The request vector is duplicated so the wrap-around search becomes a
    // plain lowest-set-bit search above rr_ptr. The upper copy is unmasked,
    // so whenever any request exists a hit is always found.
    assign dbl_req   = {req, req};
    assign prio_mask = ~(((2*N)'(1) << rr_ptr) - (2*N)'(1));
    assign masked    = dbl_req & prio_mask;
    assign any       = |req;

    always_comb begin
        first_idx = 0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (masked[j]) begin
                first_idx = j;
            end
        end
    end

    assign pick_id = (first_idx >= N) ? ID_W'(first_idx - N) : ID_W'(first_idx);

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter, registered one-hot grant, owner holds
// the grant until it drops its request, followed by one turnaround cycle.
//   clk, rst      clock; asynchronous active-high reset
//   req [N-1:0]   request vector, held high for the whole transaction
//   gnt [N-1:0]   registered one-hot grant, zero when no owner
//   gnt_valid     registered OR of gnt
//   gnt_id        registered binary owner index, 0 when no owner
//   busy          high while in GRANT or TURN
//   hold_expired  one-cycle pulse when a grant is forcibly ended
// Build option ARB_TIMEOUT_EN: grants are limited to MAX_HOLD cycles. Without
// it there is no hold counter and grants last as long as the owner requests.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; arbitrates on the next edge if any req is high
// GRANT | owner locked; other requests ignored until owner releases
// TURN  | mandatory one-cycle gap with gnt low before returning to IDLE
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    localparam int ID_W    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy,
    output logic            hold_expired
);

    arb_state_e      state;
    logic [ID_W-1:0] rr_ptr;
    logic            pick_any;
    logic [ID_W-1:0] pick_id;
    logic            owner_req;

    rr_pick #(.N(N)) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .any     (pick_any),
        .pick_id (pick_id)
    );

    // gnt is one-hot, so masking req with it isolates the owner's request bit.
    assign owner_req = |(req & gnt);
    assign busy      = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic                  hold_exp_q;

    assign hold_expired = hold_exp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            gnt_valid  <= 1'b0;
            gnt_id     <= '0;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
            hold_exp_q <= 1'b0;
        end else begin
            hold_exp_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= GRANT;
                        gnt       <= N'(1) << pick_id;
                        gnt_valid <= 1'b1;
                        gnt_id    <= pick_id;
                        rr_ptr    <= (pick_id == ID_W'(N-1)) ? '0 : pick_id + 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state     <= TURN;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        gnt_id    <= '0;
                    end else if (hold_cnt == HOLD_CNT_W'(MAX_HOLD - 1)) begin
                        // Preempted owner already sits behind everyone via rr_ptr.
                        state      <= TURN;
                        gnt        <= '0;
                        gnt_valid  <= 1'b0;
                        gnt_id     <= '0;
                        hold_exp_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    gnt_id    <= '0;
                end
            endcase
        end
    end
`else
    // MAX_HOLD only matters with the timeout; its legal range (>= 2) makes this
    // constant 0, while an illegal setting shows up as a stuck-high flag.
    assign hold_expired = (MAX_HOLD < 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            rr_ptr    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= GRANT;
                        gnt       <= N'(1) << pick_id;
                        gnt_valid <= 1'b1;
                        gnt_id    <= pick_id;
                        rr_ptr    <= (pick_id == ID_W'(N-1)) ? '0 : pick_id + 1'b1;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state     <= TURN;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        gnt_id    <= '0;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    gnt_id    <= '0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed bench for rr_arbiter (N=4 main instance, N=3 wrap
// instance). A cycle-level reference model of the arbitration rules runs
// alongside the N=4 instance and is compared on every falling edge.
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         hold_expired;

    logic [2:0]   req3 = '0;
    logic [2:0]   gnt3;
    logic         gnt_valid3;
    logic [1:0]   gnt_id3;
    logic         busy3;
    logic         hold_expired3;

    always #5 clk = ~clk;

    rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_valid(gnt_valid),
        .gnt_id(gnt_id), .busy(busy), .hold_expired(hold_expired)
    );

    rr_arbiter #(.N(3), .MAX_HOLD(MH)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .gnt(gnt3), .gnt_valid(gnt_valid3),
        .gnt_id(gnt_id3), .busy(busy3), .hold_expired(hold_expired3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_owner = -1;   // current owner index, -1 when none
    int m_ptr   = 0;    // highest-priority index
    int m_len   = 0;    // cycles the current grant has been visible
    bit m_turn  = 0;    // in the turnaround gap
    bit m_exp   = 0;

    function automatic int rr_choose(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int bin_of(input logic [N-1:0] v);
        int r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_len   <= 0;
            m_turn  <= 0;
            m_exp   <= 0;
        end else begin
            m_exp <= 0;
            if (m_owner >= 0) begin
                if (!req[m_owner]) begin
                    m_owner <= -1;
                    m_turn  <= 1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (m_len == MH) begin
                    m_owner <= -1;
                    m_turn  <= 1;
                    m_exp   <= 1;
                end
`endif
                else begin
                    m_len <= m_len + 1;
                end
            end else if (m_turn) begin
                m_turn <= 0;
            end else if (req != '0) begin
                m_owner <= rr_choose(req, m_ptr);
                m_ptr   <= (rr_choose(req, m_ptr) + 1) % N;
                m_len   <= 1;
            end
        end
    end

    bit           cmp_en = 0;
    logic [N-1:0] e_gnt;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            chk("model_gnt", 32'(gnt), 32'(e_gnt));
            chk("model_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
            chk("model_gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            chk("model_busy", 32'(busy), 32'((m_owner >= 0) || m_turn));
            chk("model_hold_expired", 32'(hold_expired), 32'(m_exp));
            chk("onehot_or_zero", 32'($countones(gnt) <= 1), 32'd1);
            chk("gnt_id_matches_gnt", 32'(gnt_id), 32'(bin_of(gnt)));
        end
    end

    // ---------------- stimulus ----------------
    int rot_exp [5] = '{0, 1, 2, 3, 0};
    int gap;
    int cnt;
    int others;
    bit seen3;
    bit prev_valid;

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1;
        @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_gnt_id", 32'(gnt_id), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hold_expired", 32'(hold_expired), 32'd0);

        // reset in the middle of a grant
        req = 4'b0010;
        @(negedge clk);
        chk("first_grant", 32'(gnt), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_gnt", 32'(gnt), 32'd0);
        chk("async_reset_valid", 32'(gnt_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        chk("post_reset_grant", 32'(gnt), 32'h1);

        // rotation with all requesting
        for (int r = 0; r < 5; r++) begin
            chk("rot_owner", 32'(gnt_id), 32'(rot_exp[r]));
            if (r < 4) begin
                @(negedge clk);
                @(negedge clk);
                req[rot_exp[r]] = 1'b0;
                @(negedge clk);
                req[rot_exp[r]] = 1'b1;
                gap = 0;
                while (!gnt_valid && gap < 10) begin
                    gap++;
                    @(negedge clk);
                end
                chk("rot_gap", 32'(gap), 32'd2);
            end
        end

        // lock: owner keeps grant while another requester rises
        req = '0;
        repeat (4) @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        chk("lock_grant", 32'(gnt), 32'h4);
        req[0] = 1'b1;
        @(negedge clk);
        chk("lock_hold1", 32'(gnt), 32'h4);
        @(negedge clk);
        chk("lock_hold2", 32'(gnt), 32'h4);
        req[2] = 1'b0;
        @(negedge clk);
        chk("lock_turn", 32'(gnt), 32'd0);
        @(negedge clk);
        chk("lock_idle", 32'(gnt), 32'd0);
        @(negedge clk);
        chk("lock_next", 32'(gnt), 32'h1);

        // timeout (or unlimited hold without the option)
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0011;
        @(negedge clk);
        cnt = 0;
        while (gnt == 4'b0001 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
`ifdef ARB_TIMEOUT_EN
        chk("timeout_len", 32'(cnt), 32'd4);
        chk("timeout_pulse", 32'(hold_expired), 32'd1);
        chk("timeout_gnt_low", 32'(gnt), 32'd0);
        @(negedge clk);
        chk("timeout_pulse_end", 32'(hold_expired), 32'd0);
        @(negedge clk);
        chk("timeout_next", 32'(gnt), 32'h2);
`else
        chk("hold_unlimited", 32'(cnt), 32'd40);
        chk("hold_no_pulse", 32'(hold_expired), 32'd0);
        chk("hold_still_owner", 32'(gnt), 32'h1);
`endif

        // starvation bound for requester 3
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        others = 0;
        seen3 = 0;
        prev_valid = 0;
        for (int c = 0; c < 200 && !seen3; c++) begin
            req = {1'b1, 3'($urandom)};
            @(negedge clk);
            if (gnt_valid && !prev_valid) begin
                if (gnt_id == 2'd3) seen3 = 1;
                else others++;
            end
            prev_valid = gnt_valid;
        end
        chk("starve_granted", 32'(seen3), 32'd1);
        chk("starve_bound", 32'(others <= 3), 32'd1);

        // random traffic, model-checked every cycle
        for (int c = 0; c < 1000; c++) begin
            req = N'($urandom);
            @(negedge clk);
        end

        // N=3 wrap from owner 2 back to 0
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req3 = 3'b100;
        @(negedge clk);
        chk("n3_grant2", 32'(gnt3), 32'h4);
        chk("n3_id2", 32'(gnt_id3), 32'd2);
        req3 = 3'b111;
        @(negedge clk);
        req3 = 3'b011;
        @(negedge clk);
        req3 = 3'b111;
        chk("n3_turn", 32'(gnt3), 32'd0);
        @(negedge clk);
        chk("n3_idle", 32'(gnt3), 32'd0);
        @(negedge clk);
        chk("n3_wrap_gnt", 32'(gnt3), 32'h1);
        chk("n3_wrap_id", 32'(gnt_id3), 32'd0);

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- N-way round-robin arbiter with a registered one-hot grant and lock-until-release semantics, sharing one resource (bus/port) between N requesters.
- Successor to the fixed-priority 3-way arbiter. Removes starvation by rotating priority after every grant.
- Inserts one mandatory turnaround cycle between consecutive grants.
- Sits between requesting masters and the shared-resource mux; gnt_id drives the mux select directly.

Parameters:
- N, 4, number of requesters; any value 2..16, power of two not required.
- MAX_HOLD, 16, maximum grant length in cycles when ARB_TIMEOUT_EN is defined; range 2..65535.
- ID_W, derived as $clog2(N), width of gnt_id; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N  request vector; req[i] held high by requester i for the whole transaction.
- gnt  out  N  one-hot registered grant; all-zero when no owner.
- gnt_valid  out  1  OR of gnt.
- gnt_id  out  ID_W  binary index of owner; 0 when gnt_valid=0.
- busy  out  1  high in GRANT or TURN state.
- hold_expired  out  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, busy=0, hold_expired=0, rr_ptr=0, hold_cnt=0. Asserting rst mid-grant drops gnt in the same cycle; no release cycle is produced.
- rr_ptr (ID_W bits) holds the highest-priority index. Pick = first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... N-1, 0, ... rr_ptr-1 (modulo N).
- IDLE: if |req, register gnt=onehot(pick), gnt_id=pick, and rr_ptr=(pick==N-1)?0:pick+1, then go to GRANT. Otherwise stay in IDLE.
- Latency: req[i] rising before edge k gives gnt[i]=1 after edge k (one cycle).
- GRANT: owner is locked. Changes on other req bits are ignored.
  - On the edge where req[owner]=0: gnt=0, go to TURN.
  - A requester dropping req in its first GRANT cycle is legal and gives a one-cycle grant.
- TURN: gnt=0 for exactly one cycle. It then goes to IDLE, which arbitrates on the next edge. Back-to-back owners are therefore separated by a guaranteed gap:
  - gnt low for TURN and IDLE cycles (2 cycles) when req is already pending;
  - first grant from idle takes 1 cycle.
- Simultaneous requests: resolved only by rr_ptr. Ties are impossible.
- Starvation bound: a held request is granted after at most N-1 other grants.
- Wrap: rr_ptr increments modulo N, including for non-power-of-two N (e.g. N=3: 2→0).
- Glitch-free: gnt, gnt_id and gnt_valid are flop outputs with no combinational path from req.
- X on req is not tolerated in IDLE. Verification treats it as a bench error.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt (16 b) clears on entry to GRANT and increments each GRANT cycle.
  - When hold_cnt==MAX_HOLD-1 and req[owner] is still 1: force gnt=0, go to TURN, and pulse hold_expired for 1 cycle coincident with gnt falling.
  - The preempted requester keeps lowest priority through the normal rr_ptr rotation.
  - A grant therefore never exceeds MAX_HOLD cycles.
- Not defined: no counter exists, a grant lasts indefinitely while req[owner]=1, and hold_expired is constant 0.

Decomposition:
- Package arb_pkg:
  - state enum IDLE=2'b00, GRANT=2'b01, TURN=2'b10;
  - HOLD_CNT_W=16;
  - function onehot_to_bin.
- Sub-module rr_pick (combinational), parameter N.
  - Inputs: req, rr_ptr.
  - Outputs: any, pick_id.
  - Implementation: double-width masked priority encode.
- Top rr_arbiter holds the FSM, the grant registers, rr_ptr and the optional hold counter.

Test Plan:
- Reset mid-grant: N=4, req=4'b0010 granted, then rst=1 asynchronously → gnt=0 within the cycle, rr_ptr=0; after release req=4'b1111 → gnt=4'b0001.
- Rotation: N=4, req=4'b1111 held; each owner drops req for 1 cycle after 3 cycles of grant → grant order 0,1,2,3,0; gnt gap exactly 2 cycles each time.
- Lock: req=4'b0100 granted, then req[0] rises → gnt stays 4'b0100 until req[2] falls; then TURN, IDLE, gnt=4'b0001.
- Non-power-of-two wrap: N=3, owner 2 released with req=3'b111 → next gnt=3'b001, gnt_id=0.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=4'b0011 held high → gnt[0] for exactly 4 cycles, hold_expired pulses with gnt fall, next grant gnt=4'b0010.
- Starvation: N=4, req[3] held high while 0..2 repeatedly re-request → gnt[3] within 3 grants; 1000-cycle random run checks gnt one-hot-or-zero and gnt_id==onehot_to_bin(gnt).
